// File: rtl/vedic_mult_8bit.sv
// Unsigned 8x8 -> 16-bit Urdhva-Tiryagbhyam multiplier with CLA partial-product summation.
// Product is registered once: one-cycle latency, one operand pair accepted per cycle.

package vedic_mult_8bit_pkg;

    // Carry into each bit of a 4-bit lookahead group (bit 0 receives cin).
    function automatic logic [3:0] cla4_carries(input logic [3:0] x, input logic [3:0] y,
                                                input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        g = x & y;
        p = x ^ y;
        cla4_carries[0] = cin;
        cla4_carries[1] = g[0] | (p[0] & cin);
        cla4_carries[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        cla4_carries[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    endfunction

    function automatic logic cla4_cout(input logic [3:0] x, input logic [3:0] y, input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        g = x & y;
        p = x ^ y;
        cla4_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin);
    endfunction

    function automatic logic [3:0] cla4_sum(input logic [3:0] x, input logic [3:0] y,
                                            input logic cin);
        cla4_sum = (x ^ y) ^ cla4_carries(x, y, cin);
    endfunction

endpackage

module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] prod
);
    logic t1, t2, t3, c1;

    assign t1 = a[1] & b[0];
    assign t2 = a[0] & b[1];
    assign t3 = a[1] & b[1];
    assign c1 = t1 & t2;

    assign prod[0] = a[0] & b[0];
    assign prod[1] = t1 ^ t2;
    assign prod[2] = t3 ^ c1;
    assign prod[3] = t3 & c1;
endmodule

module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] prod
);
    import vedic_mult_8bit_pkg::*;

    logic [3:0] ll, hl, lh, hh;
    logic [3:0] m1, m2;
    logic       m1_c, m2_c;

    vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .prod(ll));
    vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .prod(hl));
    vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .prod(lh));
    vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .prod(hh));

    assign m1   = cla4_sum(hl, lh, 1'b0);
    assign m1_c = cla4_cout(hl, lh, 1'b0);
    assign m2   = cla4_sum(m1, {2'b00, ll[3:2]}, 1'b0);
    // Middle sum is at most 9+9+3=21, so only one of the two carries can be set.
    assign m2_c = m1_c | cla4_cout(m1, {2'b00, ll[3:2]}, 1'b0);

    assign prod[1:0] = ll[1:0];
    assign prod[3:2] = m2[1:0];
    assign prod[7:4] = cla4_sum(hh, {1'b0, m2_c, m2[3:2]}, 1'b0);
endmodule

module vedic_mult_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] out
);
    import vedic_mult_8bit_pkg::*;

    logic [7:0] q0, q1, q2, q3;
    logic [8:0] s1, s2;
    logic       s1_c4, s2_c4, s2_c8, hi_c4;
    logic [7:0] hi;

    vedic_4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .prod(q0));
    vedic_4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .prod(q1));
    vedic_4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .prod(q2));
    vedic_4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .prod(q3));

    assign s1[3:0] = cla4_sum(q1[3:0], q2[3:0], 1'b0);
    assign s1_c4   = cla4_cout(q1[3:0], q2[3:0], 1'b0);
    assign s1[7:4] = cla4_sum(q1[7:4], q2[7:4], s1_c4);
    assign s1[8]   = cla4_cout(q1[7:4], q2[7:4], s1_c4);

    assign s2[3:0] = cla4_sum(s1[3:0], q0[7:4], 1'b0);
    assign s2_c4   = cla4_cout(s1[3:0], q0[7:4], 1'b0);
    assign s2[7:4] = cla4_sum(s1[7:4], 4'b0000, s2_c4);
    assign s2_c8   = cla4_cout(s1[7:4], 4'b0000, s2_c4);
    // s1 + q0[7:4] <= 225+225+15 < 512, so bit 8 never receives two carries.
    assign s2[8]   = s1[8] | s2_c8;

    assign hi[3:0] = cla4_sum(q3[3:0], s2[7:4], 1'b0);
    assign hi_c4   = cla4_cout(q3[3:0], s2[7:4], 1'b0);
    assign hi[7:4] = cla4_sum(q3[7:4], {3'b000, s2[8]}, hi_c4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= {hi, s2[3:0], q0[3:0]};
        end
    end
endmodule

// File: tb/tb_vedic_mult_8bit.sv
// Self-checking bench for vedic_mult_8bit: directed vectors, corners, resets,
// randomized and exhaustive operands against a plain-arithmetic product model.

module tb_vedic_mult_8bit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] out;

    int unsigned n_compared = 0;
    int unsigned n_mismatched = 0;

    vedic_mult_8bit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: the registered output after an edge is either 0 (reset) or a*b.
    function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mr);
        int unsigned p;
        p = int'(ma) * int'(mb);
        return mr ? p[15:0] : 16'd0;
    endfunction

    // Apply inputs, take one edge, check just after it and again mid-cycle.
    task automatic step(input logic [7:0] na, input logic [7:0] nb, input logic nr,
                        input string tag);
        logic [15:0] exp;
        a     = na;
        b     = nb;
        rst_n = nr;
        exp   = model(na, nb, nr);
        @(posedge clk);
        #1;
        check_eq(tag, out, exp);
        @(negedge clk);
        check_eq({tag, "_hold"}, out, exp);
    endtask

    // Exhaustive sweep: check once per edge to keep the run short.
    task automatic step_fast(input logic [7:0] na, input logic [7:0] nb);
        a     = na;
        b     = nb;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("exhaustive", out, model(na, nb, 1'b1));
    endtask

    initial begin
        a     = 8'd25;
        b     = 8'd27;
        rst_n = 1'b0;

        step(8'd25, 8'd27, 1'b0, "reset_1");
        step(8'd25, 8'd27, 1'b0, "reset_2");
        step(8'd25, 8'd27, 1'b1, "release_675");
        check_eq("release_675_const", out, 16'd675);

        step(8'd5,  8'd8,  1'b1, "vec_5x8");
        check_eq("vec_5x8_const", out, 16'd40);
        step(8'd15, 8'd15, 1'b1, "vec_15x15");
        step(8'd25, 8'd27, 1'b1, "vec_25x27");
        step(8'd19, 8'd20, 1'b1, "vec_19x20");
        check_eq("vec_19x20_const", out, 16'd380);

        step(8'd0,   8'd173, 1'b1, "corner_0x173");
        step(8'd1,   8'd200, 1'b1, "corner_1x200");
        step(8'd255, 8'd1,   1'b1, "corner_255x1");
        step(8'd255, 8'd255, 1'b1, "corner_255x255");
        check_eq("corner_max_const", out, 16'hFE01);
        step(8'd16,  8'd16,  1'b1, "corner_16x16");
        check_eq("corner_16x16_const", out, 16'd256);

        step(8'd19, 8'd20, 1'b0, "midreset_zero");
        step(8'd19, 8'd20, 1'b1, "midreset_380");

        for (int i = 0; i < 5; i++) begin
            step(8'd15, 8'd15, 1'b1, "hold_225");
        end

        for (int i = 0; i < 2000; i++) begin
            logic [7:0] ra, rb;
            logic       rr;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rr = ($urandom_range(0, 31) != 0);
            step(ra, rb, rr, "random");
        end

        for (int i = 0; i < 65536; i++) begin
            logic [15:0] v;
            v = 16'(i);
            step_fast(v[15:8], v[7:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
